// File: rtl/pool_pkg.sv
// Shared constants for the pooling stage and the blocks around it
// (conv engine, feature buffers).
package pool_pkg;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_AVG = 1'b1;

    // Defaults shared with the conv and feature-buffer blocks.
    localparam int POOL_CH  = 16;
    localparam int POOL_DW  = 16;
    localparam int POOL_WIN = 4;

    // True when n is a power of two and at least 2. This is the legal set of window sizes.
    function automatic bit win_ok(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/pool_array_if.sv
// Stream bus of the pooling array: sample input, window control,
// pooled result output and the busy flag.
interface pool_array_if #(
    parameter int CH = 16,
    parameter int DW = 16
);
    logic              in_valid;
    logic [CH*DW-1:0]  in_data;
    logic              pool_clr;
    logic              mode;
    logic              out_valid;
    logic [CH*DW-1:0]  out_data;
    logic              busy;

    modport master (
        output in_valid, in_data, pool_clr, mode,
        input  out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, pool_clr, mode,
        output out_valid, out_data, busy
    );
endinterface

// File: rtl/pool_lane.sv
// One pooling lane: the accumulator, the max/add datapath and the result register.
// With POOL_AVG_EN undefined, only the max datapath is built and mode is ignored.
module pool_lane
    import pool_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic          accum,
    input  logic          done,
    input  logic          mode,
    input  logic [DW-1:0] sample,
    output logic [DW-1:0] result
);

`ifdef POOL_AVG_EN
    // A window sum of 2**CW samples needs CW bits of headroom, so it cannot overflow.
    localparam int AW = DW + CW;
`else
    localparam int AW = DW;
`endif

    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] samp_ext;
    logic signed [AW-1:0] max_val;
    logic signed [AW-1:0] comb_val;
    logic        [DW-1:0] res_val;
    logic        [DW-1:0] result_q, result_d;

    assign samp_ext = AW'($signed(sample));
    assign max_val  = (samp_ext > acc_q) ? samp_ext : acc_q;

`ifdef POOL_AVG_EN
    logic signed [AW-1:0] sum_val;
    logic        [DW-1:0] avg_res;

    assign sum_val = acc_q + samp_ext;
    // An arithmetic shift rounds toward minus infinity, so the result is the floor of the mean.
    assign avg_res = DW'(sum_val >>> CW);

    always_comb begin
        comb_val = max_val;
        res_val  = DW'(max_val);
        if (mode == MODE_AVG) begin
            comb_val = sum_val;
            res_val  = avg_res;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign comb_val    = max_val;
    assign res_val     = DW'(max_val);
`endif

    always_comb begin
        acc_d    = acc_q;
        result_d = result_q;
        if (clr) begin
            acc_d = '0;
        end
        if (load) begin
            acc_d = samp_ext;
        end else if (accum) begin
            acc_d = comb_val;
        end
        if (done) begin
            result_d = res_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/pool_array.sv
// Multi-channel pooling engine. It reduces every WIN accepted samples to one max or average per lane.
// The average datapath exists only when POOL_AVG_EN is defined.
module pool_array
    import pool_pkg::*;
#(
    parameter  int CH  = POOL_CH,
    parameter  int DW  = POOL_DW,
    parameter  int WIN = POOL_WIN,
    localparam int CW  = $clog2(WIN)
) (
    input  logic     clk,
    input  logic     rst_n,
    pool_array_if.slave io
);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             lane_load;
    logic             lane_accum;
    logic             complete;
    logic [CH*DW-1:0] lane_res;

    // Clearing and accepting a sample together starts a new window with this sample as element 0.
    assign lane_load  = io.in_valid && (io.pool_clr || (cnt_q == '0));
    assign lane_accum = io.in_valid && !lane_load;
    assign complete   = io.in_valid && !io.pool_clr && (cnt_q == CW'(WIN - 1));

    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = complete;
        if (io.in_valid) begin
            // WIN is a power of two, so the natural CW-bit wrap ends the window.
            cnt_d = io.pool_clr ? CW'(1) : cnt_q + CW'(1);
        end else if (io.pool_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_lane
        pool_lane #(
            .DW (DW),
            .CW (CW)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (io.pool_clr),
            .load   (lane_load),
            .accum  (lane_accum),
            .done   (complete),
            .mode   (io.mode),
            .sample (io.in_data[gi*DW +: DW]),
            .result (lane_res[gi*DW +: DW])
        );
    end

    assign io.out_valid = out_valid_q;
    assign io.out_data  = lane_res;
    assign io.busy      = (cnt_q != '0);

endmodule

// File: tb/tb_pool_array.sv
// Directed bench for pool_array (CH=16, DW=16, WIN=4). The expectations for the average
// vectors depend on whether POOL_AVG_EN is defined.
module tb_pool_array;
    import pool_pkg::*;

    localparam int CH  = 16;
    localparam int DW  = 16;
    localparam int WIN = 4;
    localparam int W   = CH * DW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pool_array_if #(.CH(CH), .DW(DW)) bus ();

    pool_array #(.CH(CH), .DW(DW), .WIN(WIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int snap;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] lanes(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        logic [W-1:0] r;
        r = '0;
        r[0*DW +: DW] = a;
        r[1*DW +: DW] = b;
        r[2*DW +: DW] = c;
        return r;
    endfunction

    // Drives one cycle starting at a negedge. On return the outputs reflect that posedge.
    task automatic push(input logic v, input logic clr, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] c);
        bus.in_valid = v;
        bus.pool_clr = clr;
        bus.in_data  = lanes(a, b, c);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.pool_clr = 1'b0;
        $display("cyc v=%0b clr=%0b l0=%0d l1=%0d l2=%0d -> out_valid=%0b busy=%0b out0=%0d",
                 v, clr, $signed(a), $signed(b), $signed(c), bus.out_valid, bus.busy,
                 $signed(bus.out_data[DW-1:0]));
    endtask

    task automatic idle();
        push(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.pool_clr = 1'b0;
        bus.in_data  = '0;
        bus.mode     = MODE_MAX;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_busy",      W'(bus.busy),      W'(0));
        check("rst_out_data",  bus.out_data,      '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Max mode. Lane 1 carries only negative samples, which exercises the signed compare.
        snap = pulses;
        push(1'b1, 1'b0, 16'd5,        -16'sd4, '0);
        check("max_busy_1", W'(bus.busy), W'(1));
        push(1'b1, 1'b0, -16'sd3,      -16'sd2, '0);
        push(1'b1, 1'b0, 16'd9,        -16'sd7, '0);
        check("max_no_early_valid", W'(bus.out_valid), W'(0));
        push(1'b1, 1'b0, 16'd2,        -16'sd9, '0);
        check("max_valid",  W'(bus.out_valid), W'(1));
        check("max_data",   bus.out_data, lanes(16'd9, 16'hFFFE, '0));
        check("max_busy_0", W'(bus.busy), W'(0));
        idle();
        check("max_pulse_end", W'(bus.out_valid), W'(0));
        check("max_hold",      bus.out_data, lanes(16'd9, 16'hFFFE, '0));
        check("max_pulses",    W'(pulses - snap), W'(1));

        // Average vectors. Without the average datapath the same window gives the max.
        bus.mode = MODE_AVG;
        push(1'b1, 1'b0, 16'd7,  16'hFFFF, 16'h7FFF);
        push(1'b1, 1'b0, 16'd8,  16'hFFFF, 16'h7FFF);
        push(1'b1, 1'b0, 16'd9,  16'hFFFF, 16'h7FFF);
        push(1'b1, 1'b0, 16'd10, 16'hFFFE, 16'h7FFF);
        check("avg_valid", W'(bus.out_valid), W'(1));
`ifdef POOL_AVG_EN
        check("avg_data", bus.out_data, lanes(16'd8, 16'hFFFE, 16'h7FFF));
`else
        check("mode_ignored_data", bus.out_data, lanes(16'd10, 16'hFFFF, 16'h7FFF));
`endif
        bus.mode = MODE_MAX;
        idle();

        // Gapped input: two idle cycles between the samples.
        snap = pulses;
        for (int i = 1; i <= 4; i++) begin
            push(1'b1, 1'b0, DW'(i), '0, '0);
            if (i < 4) begin
                idle();
                idle();
                check($sformatf("gap_busy_%0d", i),  W'(bus.busy),      W'(1));
                check($sformatf("gap_quiet_%0d", i), W'(bus.out_valid), W'(0));
            end
        end
        check("gap_valid", W'(bus.out_valid), W'(1));
        check("gap_data",  bus.out_data, lanes(16'd4, '0, '0));
        check("gap_busy",  W'(bus.busy), W'(0));
        idle();
        check("gap_pulses", W'(pulses - snap), W'(1));

        // pool_clr arrives together with a sample while cnt == WIN-1.
        snap = pulses;
        push(1'b1, 1'b0, 16'd50, '0, '0);
        push(1'b1, 1'b0, 16'd60, '0, '0);
        push(1'b1, 1'b0, 16'd70, '0, '0);
        push(1'b1, 1'b1, 16'd100, '0, '0);
        check("clr_no_valid", W'(bus.out_valid), W'(0));
        check("clr_busy_cnt1", W'(bus.busy), W'(1));
        check("clr_data_kept", bus.out_data, lanes(16'd4, '0, '0));
        push(1'b1, 1'b0, 16'd1, '0, '0);
        push(1'b1, 1'b0, 16'd1, '0, '0);
        check("clr_no_early", W'(bus.out_valid), W'(0));
        push(1'b1, 1'b0, 16'd1, '0, '0);
        check("clr_valid", W'(bus.out_valid), W'(1));
        check("clr_data",  bus.out_data, lanes(16'd100, '0, '0));
        idle();
        check("clr_pulses", W'(pulses - snap), W'(1));

        // pool_clr without a sample abandons the partial window.
        push(1'b1, 1'b0, 16'd200, '0, '0);
        push(1'b1, 1'b0, 16'd200, '0, '0);
        push(1'b0, 1'b1, '0, '0, '0);
        check("clr_only_busy",  W'(bus.busy), W'(0));
        check("clr_only_valid", W'(bus.out_valid), W'(0));
        check("clr_only_data",  bus.out_data, lanes(16'd100, '0, '0));
        for (int i = 0; i < WIN; i++) push(1'b1, 1'b0, 16'd3, '0, '0);
        check("after_clr_data", bus.out_data, lanes(16'd3, '0, '0));

        // Asynchronous reset in the middle of a window.
        idle();
        push(1'b1, 1'b0, 16'd50, '0, '0);
        push(1'b1, 1'b0, 16'd50, '0, '0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data", bus.out_data, '0);
        check("arst_busy", W'(bus.busy), W'(0));
        check("arst_valid", W'(bus.out_valid), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        snap = pulses;
        for (int i = 0; i < WIN; i++) push(1'b1, 1'b0, 16'd6, '0, '0);
        check("arst_result_valid", W'(bus.out_valid), W'(1));
        check("arst_result", bus.out_data, lanes(16'd6, '0, '0));
        idle();
        idle();
        check("arst_pulses", W'(pulses - snap), W'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
